brom_arbiter: RTL and testbench
===============================

# brom_arbiter

Shares the single-port boot ROM between two requesters: port A (instruction fetch) and port B (data load). Round-robin arbitration, one ROM transaction in flight at a time. Registered request/response sequencing toward the ROM, an out-of-range and misalignment check, and a response timeout so a requester can never hang. Sits between the CPU fetch/load buses and the ROM block, which takes a request and returns ready plus data one cycle later.

## Interface
- ROM_WORDS, 1024, ROM depth in 32-bit words; valid byte addresses are 0 .. 4*ROM_WORDS-1.
- TIMEOUT, 15, max cycles spent in WAIT before forced error completion; must be ≥2, counter width $clog2(TIMEOUT+1).
- i_clock  in  1  single clock, all logic on posedge.
- i_reset_n  in  1  synchronous, active-low reset.
- i_a_request / i_b_request  in  1  requester holds high, with stable address, until its o_x_ready pulse.
- i_a_address / i_b_address  in  32  byte address.
- o_a_rdata / o_b_rdata  out  32  read data, valid only while o_x_ready=1.
- o_a_ready / o_b_ready  out  1  one-cycle completion pulse.
- o_a_error / o_b_error  out  1  qualifies o_x_ready: range, alignment or timeout fault.
- o_rom_request  out  1  one-cycle request to the ROM.
- o_rom_address  out  32  byte address to the ROM, word-aligned.
- i_rom_rdata  in  32  ROM read data.
- i_rom_ready  in  1  ROM completion.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise pick the winner: the single requester if only one is active; if both are active, the one not granted last. The last-grant pointer resets to B, so A wins the first tie.
  - Latch the winner id and address.
  - If the address is ≥4*ROM_WORDS or address[1:0]≠0, go to RESPOND with error=1 and rdata=0; the ROM is not accessed.
  - Otherwise go to ISSUE.
- ISSUE:
  - o_rom_request=1 for exactly this cycle; o_rom_address holds the latched address.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - o_rom_request=0.
  - If i_rom_ready=1, capture i_rom_rdata and go to RESPOND with error=0.
  - Else increment the counter. When the counter reaches TIMEOUT, go to RESPOND with error=1 and rdata=0.
- RESPOND:
  - Only the granted port sees o_x_ready=1, carrying the captured rdata/error.
  - Update the last-grant pointer and return to IDLE.
  - No arbitration happens this cycle, so a requester still holding its request is never re-granted.
- i_rom_ready outside WAIT is ignored. This covers a late response after a timeout or reset.
- The requester address may change after its ready pulse; it is latched in IDLE.

## Timing
- All outputs are registered.
- Reset values: o_x_ready=0, o_x_error=0, o_x_rdata=0, o_rom_request=0, o_rom_address=0, state IDLE.
- Normal read (request first seen high in cycle N in IDLE):
  - o_rom_request is high in N+1.
  - i_rom_ready arrives in N+2.
  - o_x_ready is high in N+3.
  - IDLE again in N+4.
  - Latency 3 cycles; back-to-back throughput 1 transaction per 4 cycles.
- Range/alignment error: o_x_ready=1, o_x_error=1 in N+1; IDLE in N+2.
- Timeout: o_x_ready with error in N+2+TIMEOUT+1.
- Simultaneous A and B requests: served alternately, A,B,A,B…; each waits at most one other transaction.
- Reset asserted mid-transaction: next cycle in IDLE with all outputs at reset values. No ready pulse is issued for the aborted access, and the requester must re-present its request.
- o_a_ready and o_b_ready are never high in the same cycle.

## Structure
- Package brom_arbiter_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESPOND);
  - the port-id typedef (PORT_A, PORT_B);
  - the error-cause constants.
- One sub-module, rr_arbiter2: a two-input round-robin grant with a last-grant input, purely combinational. The FSM owns the last-grant register.
- Everything else is flat in brom_arbiter.

## Test plan
- Single A read at 0x10, ROM model returns 0xDEADBEEF → o_rom_request high for exactly 1 cycle with address 0x10; o_a_ready=1, o_a_rdata=0xDEADBEEF, o_a_error=0 at 3 cycles after the request; o_b_ready stays 0.
- A and B both request at cycle 0, holding for 3 transactions each → grant order A,B,A,B,A,B; ready pulses 4 cycles apart; no double grant in a RESPOND cycle.
- B reads 0x1000 with ROM_WORDS=1024, and separately 0x6 → o_b_ready=1, o_b_error=1, o_b_rdata=0 one cycle later; o_rom_request never asserted.
- ROM model never answers, TIMEOUT=15 → o_a_ready=1 with error exactly 18 cycles after the request; a late i_rom_ready afterwards produces no extra pulse.
- i_reset_n pulled low for one cycle while in WAIT → outputs zero, FSM in IDLE, stale i_rom_ready ignored; the re-issued request then completes normally.

Source files
------------

// File: rtl/brom_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : brom_arbiter_pkg
//  Description : Shared types and constants for the boot-ROM arbiter:
//                FSM state encoding, requester id and error-cause codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package brom_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    // Why a transaction completes; anything other than none raises o_x_error.
    typedef logic [1:0] err_cause_t;
    localparam err_cause_t c_err_none    = 2'd0;
    localparam err_cause_t c_err_range   = 2'd1;
    localparam err_cause_t c_err_align   = 2'd2;
    localparam err_cause_t c_err_timeout = 2'd3;

endpackage
`default_nettype wire

// File: rtl/brom_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : brom_arbiter_if
//  Description : Bus bundle between the two CPU requesters, the arbiter and
//                the boot ROM. Names are from the arbiter's point of view.
//  Ports       : a/b request+address in, a/b rdata/ready/error out,
//                rom request/address out, rom rdata/ready in.
//  Modports    : slave  - the arbiter
//                master - the environment (requesters + ROM)
//  Revision    : 1.0 - initial release
// ============================================================================
interface brom_arbiter_if;
    logic        i_a_request;
    logic [31:0] i_a_address;
    logic [31:0] o_a_rdata;
    logic        o_a_ready;
    logic        o_a_error;

    logic        i_b_request;
    logic [31:0] i_b_address;
    logic [31:0] o_b_rdata;
    logic        o_b_ready;
    logic        o_b_error;

    logic        o_rom_request;
    logic [31:0] o_rom_address;
    logic [31:0] i_rom_rdata;
    logic        i_rom_ready;

    modport slave (
        input  i_a_request, i_a_address, i_b_request, i_b_address,
        input  i_rom_rdata, i_rom_ready,
        output o_a_rdata, o_a_ready, o_a_error,
        output o_b_rdata, o_b_ready, o_b_error,
        output o_rom_request, o_rom_address
    );

    modport master (
        output i_a_request, i_a_address, i_b_request, i_b_address,
        output i_rom_rdata, i_rom_ready,
        input  o_a_rdata, o_a_ready, o_a_error,
        input  o_b_rdata, o_b_ready, o_b_error,
        input  o_rom_request, o_rom_address
    );
endinterface
`default_nettype wire

// File: rtl/brom_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-input round-robin grant, purely combinational. On a tie
//                the port that was not granted last wins.
//  Ports       : i_req_a, i_req_b  - requests
//                i_last_grant      - port granted by the previous transaction
//                o_valid           - at least one request present
//                o_grant           - winning port (meaningful when o_valid)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import brom_arbiter_pkg::*;
(
    input  wire logic     i_req_a,
    input  wire logic     i_req_b,
    input  wire port_id_t i_last_grant,
    output logic          o_valid,
    output port_id_t      o_grant
);

    always_comb begin
        o_valid = i_req_a | i_req_b;
        o_grant = PORT_A;
        if (i_req_a && i_req_b) begin
            o_grant = (i_last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (i_req_b) begin
            o_grant = PORT_B;
        end
    end

endmodule
`default_nettype wire

// File: rtl/brom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : brom_arbiter
//  Description : Shares the single-port boot ROM between instruction fetch
//                (port A) and data load (port B). One ROM access in flight,
//                round-robin on ties, range/alignment check and a response
//                timeout so a requester never hangs. All outputs registered.
//  Ports       : i_clock   - clock, posedge
//                i_reset_n - synchronous active-low reset
//                bus       - requester and ROM signals (brom_arbiter_if.slave)
//  Revision    : 1.0 - initial release
// ============================================================================
module brom_arbiter
    import brom_arbiter_pkg::*;
#(
    parameter int ROM_WORDS = 1024,
    parameter int TIMEOUT   = 15
) (
    input  wire logic     i_clock,
    input  wire logic     i_reset_n,
    brom_arbiter_if.slave bus
);

    localparam int                 c_cnt_w     = $clog2(TIMEOUT + 1);
    localparam logic [31:0]        c_rom_bytes = 32'(4 * ROM_WORDS);
    localparam logic [c_cnt_w-1:0] c_timeout   = c_cnt_w'(TIMEOUT);

    state_t             r_state, w_next_state;
    port_id_t           r_grant, w_next_grant;
    port_id_t           r_last_grant, w_next_last_grant;
    logic [c_cnt_w-1:0] r_cnt, w_next_cnt;
    logic [31:0]        r_rom_address, w_next_rom_address;
    logic               r_rom_request;
    logic               r_a_ready, r_a_error, r_b_ready, r_b_error;
    logic [31:0]        r_a_rdata, r_b_rdata;

    logic               w_arb_valid;
    port_id_t           w_arb_grant;
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_resp_data;
    err_cause_t         w_resp_cause;
    logic               w_resp_a, w_resp_b;

    rr_arbiter2 u_rr (
        .i_req_a      (bus.i_a_request),
        .i_req_b      (bus.i_b_request),
        .i_last_grant (r_last_grant),
        .o_valid      (w_arb_valid),
        .o_grant      (w_arb_grant)
    );

    assign w_sel_addr = (w_arb_grant == PORT_A) ? bus.i_a_address : bus.i_b_address;

    // Next-state logic. w_resp_* carry the completion being registered into
    // the output flops on the transition into RESPOND.
    always_comb begin
        w_next_state       = r_state;
        w_next_grant       = r_grant;
        w_next_last_grant  = r_last_grant;
        w_next_cnt         = r_cnt;
        w_next_rom_address = r_rom_address;
        w_resp_data        = '0;
        w_resp_cause       = c_err_none;

        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_next_grant = w_arb_grant;
                    if (w_sel_addr >= c_rom_bytes) begin
                        w_resp_cause = c_err_range;
                        w_next_state = RESPOND;
                    end else if (w_sel_addr[1:0] != 2'b00) begin
                        w_resp_cause = c_err_align;
                        w_next_state = RESPOND;
                    end else begin
                        w_next_rom_address = w_sel_addr;
                        w_next_state       = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_next_cnt   = '0;
                w_next_state = WAIT;
            end
            WAIT: begin
                // A real ROM answer takes priority over a coincident timeout.
                if (bus.i_rom_ready) begin
                    w_resp_data  = bus.i_rom_rdata;
                    w_next_state = RESPOND;
                end else if (r_cnt == c_timeout) begin
                    w_resp_cause = c_err_timeout;
                    w_next_state = RESPOND;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            RESPOND: begin
                // No arbitration here: a requester still holding request
                // after its pulse cannot be granted twice.
                w_next_last_grant = r_grant;
                w_next_state      = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_resp_a = (w_next_state == RESPOND) && (w_next_grant == PORT_A);
    assign w_resp_b = (w_next_state == RESPOND) && (w_next_grant == PORT_B);

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state       <= IDLE;
            r_grant       <= PORT_A;
            r_last_grant  <= PORT_B;
            r_cnt         <= '0;
            r_rom_address <= '0;
            r_rom_request <= 1'b0;
            r_a_ready     <= 1'b0;
            r_a_error     <= 1'b0;
            r_a_rdata     <= '0;
            r_b_ready     <= 1'b0;
            r_b_error     <= 1'b0;
            r_b_rdata     <= '0;
        end else begin
            r_state       <= w_next_state;
            r_grant       <= w_next_grant;
            r_last_grant  <= w_next_last_grant;
            r_cnt         <= w_next_cnt;
            r_rom_address <= w_next_rom_address;
            r_rom_request <= (w_next_state == ISSUE);
            r_a_ready     <= w_resp_a;
            r_a_error     <= w_resp_a && (w_resp_cause != c_err_none);
            r_a_rdata     <= w_resp_a ? w_resp_data : '0;
            r_b_ready     <= w_resp_b;
            r_b_error     <= w_resp_b && (w_resp_cause != c_err_none);
            r_b_rdata     <= w_resp_b ? w_resp_data : '0;
        end
    end

    assign bus.o_rom_request = r_rom_request;
    assign bus.o_rom_address = r_rom_address;
    assign bus.o_a_ready     = r_a_ready;
    assign bus.o_a_error     = r_a_error;
    assign bus.o_a_rdata     = r_a_rdata;
    assign bus.o_b_ready     = r_b_ready;
    assign bus.o_b_error     = r_b_error;
    assign bus.o_b_rdata     = r_b_rdata;

endmodule
`default_nettype wire

// File: tb/tb_brom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_brom_arbiter
//  Description : Self-checking bench for brom_arbiter: directed vector table,
//                multi-cycle corner sequences and randomized traffic checked
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_brom_arbiter;

    localparam int ROM_WORDS = 1024;
    localparam int TIMEOUT   = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    brom_arbiter_if bus ();

    brom_arbiter #(.ROM_WORDS(ROM_WORDS), .TIMEOUT(TIMEOUT)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int rom_req_cnt = 0;

    // ROM contents as seen by the bench.
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : {~a[15:0], a[15:0]};
    endfunction

    // Reference model: what a requester must receive for a given address.
    function automatic logic model_err(input logic [31:0] a);
        return (a >= 32'(4 * ROM_WORDS)) || ((a % 4) != 0);
    endfunction
    function automatic logic [31:0] model_data(input logic [31:0] a);
        return model_err(a) ? 32'h0 : rom_fn(a);
    endfunction

    // ROM model: answers one cycle after a request unless muted.
    logic        rom_en, rom_force, rom_ready_q;
    logic [31:0] rom_data_q;
    always @(posedge clk) begin
        rom_ready_q <= bus.o_rom_request & rom_en;
        rom_data_q  <= rom_fn(bus.o_rom_address);
    end
    assign bus.i_rom_ready = rom_ready_q | rom_force;
    assign bus.i_rom_rdata = rom_data_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_ready(input bit p);
        return p ? bus.o_b_ready : bus.o_a_ready;
    endfunction
    function automatic logic get_error(input bit p);
        return p ? bus.o_b_error : bus.o_a_error;
    endfunction
    function automatic logic [31:0] get_rdata(input bit p);
        return p ? bus.o_b_rdata : bus.o_a_rdata;
    endfunction

    task automatic set_req(input bit p, input logic v, input logic [31:0] a);
        if (p) begin
            bus.i_b_request = v;
            bus.i_b_address = a;
        end else begin
            bus.i_a_request = v;
            bus.i_a_address = a;
        end
    endtask

    // One clock; outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
        if (bus.o_rom_request) rom_req_cnt++;
        chk("no_double_ready", 32'(bus.o_a_ready & bus.o_b_ready), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_ready"}, 32'(bus.o_a_ready), 32'd0);
        chk({tag, "_b_ready"}, 32'(bus.o_b_ready), 32'd0);
        chk({tag, "_a_error"}, 32'(bus.o_a_error), 32'd0);
        chk({tag, "_b_error"}, 32'(bus.o_b_error), 32'd0);
        chk({tag, "_a_rdata"}, bus.o_a_rdata, 32'd0);
        chk({tag, "_b_rdata"}, bus.o_b_rdata, 32'd0);
        chk({tag, "_rom_req"}, 32'(bus.o_rom_request), 32'd0);
        chk({tag, "_rom_addr"}, bus.o_rom_address, 32'd0);
    endtask

    task automatic wait_ready(input bit p, input int budget, output int lat,
                              output logic [31:0] data, output logic err, output bit other);
        lat = -1; data = '0; err = 1'b0; other = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (get_ready(!p)) other = 1'b1;
            if (get_ready(p)) begin
                lat  = i;
                data = get_rdata(p);
                err  = get_error(p);
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          port;
        logic [31:0] addr;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          lat;
        logic [31:0] data;
        logic        err;
        bit          other;

        vecs[0] = '{1'b0, 32'h0000_0010, 1'b0, 32'hDEADBEEF, 3};
        vecs[1] = '{1'b1, 32'h0000_1000, 1'b1, 32'h0,        1};
        vecs[2] = '{1'b1, 32'h0000_0006, 1'b1, 32'h0,        1};
        vecs[3] = '{1'b0, 32'h0000_0FFC, 1'b0, 32'hF003_0FFC, 3};
        vecs[4] = '{1'b1, 32'h0000_0020, 1'b0, 32'hFFDF_0020, 3};
        vecs[5] = '{1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0,        1};
        vecs[6] = '{1'b1, 32'h0000_0000, 1'b0, 32'hFFFF_0000, 3};
        vecs[7] = '{1'b0, 32'h0000_1001, 1'b1, 32'h0,        1};
        vecs[8] = '{1'b0, 32'h0000_0002, 1'b1, 32'h0,        1};

        rst_n = 1'b0; rom_en = 1'b1; rom_force = 1'b0;
        set_req(1'b0, 1'b0, 32'h0);
        set_req(1'b1, 1'b0, 32'h0);
        tick(); tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // ---------------- directed single-requester table ----------------
        foreach (vecs[i]) begin
            rom_req_cnt = 0;
            set_req(vecs[i].port, 1'b1, vecs[i].addr);
            wait_ready(vecs[i].port, 25, lat, data, err, other);
            set_req(vecs[i].port, 1'b0, 32'h0);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_rdata", i), data, vecs[i].exp_data);
            chk($sformatf("vec%0d_error", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_other_ready", i), 32'(other), 32'd0);
            chk($sformatf("vec%0d_rom_requests", i), 32'(rom_req_cnt),
                vecs[i].exp_err ? 32'd0 : 32'd1);
            tick(); tick();
        end

        // ---------------- simultaneous A/B: alternation after reset -------
        begin
            int   order[$];
            int   when[$];
            int   na = 0, nb = 0;
            apply_reset();
            tick();
            set_req(1'b0, 1'b1, 32'h100);
            set_req(1'b1, 1'b1, 32'h200);
            for (int t = 1; t <= 40; t++) begin
                tick();
                if (bus.o_a_ready) begin
                    chk("alt_a_rdata", bus.o_a_rdata, rom_fn(32'h100 + 32'(4 * na)));
                    order.push_back(0); when.push_back(t); na++;
                    set_req(1'b0, na < 3, 32'h100 + 32'(4 * na));
                end
                if (bus.o_b_ready) begin
                    chk("alt_b_rdata", bus.o_b_rdata, rom_fn(32'h200 + 32'(4 * nb)));
                    order.push_back(1); when.push_back(t); nb++;
                    set_req(1'b1, nb < 3, 32'h200 + 32'(4 * nb));
                end
                if (na == 3 && nb == 3) break;
            end
            chk("alt_count", 32'(order.size()), 32'd6);
            for (int k = 0; k < order.size(); k++) begin
                chk($sformatf("alt_order%0d", k), 32'(order[k]), 32'(k % 2));
                if (k == 0) chk("alt_first_latency", 32'(when[0]), 32'd3);
                else        chk($sformatf("alt_spacing%0d", k), 32'(when[k] - when[k-1]), 32'd4);
            end
            set_req(1'b0, 1'b0, 32'h0);
            set_req(1'b1, 1'b0, 32'h0);
            tick(); tick();
        end

        // ---------------- timeout, then a late ROM answer ----------------
        begin
            int late = 0;
            rom_en = 1'b0;
            rom_req_cnt = 0;
            set_req(1'b0, 1'b1, 32'h40);
            wait_ready(1'b0, 30, lat, data, err, other);
            set_req(1'b0, 1'b0, 32'h0);
            chk("timeout_latency", 32'(lat), 32'(TIMEOUT + 3));
            chk("timeout_error", 32'(err), 32'd1);
            chk("timeout_rdata", data, 32'd0);
            chk("timeout_rom_requests", 32'(rom_req_cnt), 32'd1);
            rom_force = 1'b1;
            tick();
            rom_force = 1'b0;
            if (bus.o_a_ready | bus.o_b_ready) late++;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (bus.o_a_ready | bus.o_b_ready) late++;
            end
            chk("late_ready_pulses", 32'(late), 32'd0);
            rom_en = 1'b1;
        end

        // ---------------- reset while in WAIT ----------------
        rom_en = 1'b0;
        set_req(1'b0, 1'b1, 32'h80);
        tick(); tick();
        rst_n = 1'b0;
        rom_force = 1'b1;
        tick();
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        set_req(1'b0, 1'b0, 32'h0);
        tick();
        chk("stale_ready_a", 32'(bus.o_a_ready), 32'd0);
        chk("stale_rom_req", 32'(bus.o_rom_request), 32'd0);
        rom_force = 1'b0;
        rom_en = 1'b1;
        tick();
        set_req(1'b0, 1'b1, 32'h80);
        wait_ready(1'b0, 25, lat, data, err, other);
        set_req(1'b0, 1'b0, 32'h0);
        chk("reissue_latency", 32'(lat), 32'd3);
        chk("reissue_rdata", data, rom_fn(32'h80));
        chk("reissue_error", 32'(err), 32'd0);
        tick(); tick();

        // ---------------- randomized traffic vs reference model ----------
        begin
            bit          act[2];
            logic [31:0] addr[2];
            int          start[2];
            int          gap[2];
            act = '{1'b0, 1'b0};
            gap = '{0, 0};
            for (int t = 0; t < 1500; t++) begin
                tick();
                for (int p = 0; p < 2; p++) begin
                    logic rdy;
                    rdy = get_ready(p[0]);
                    if (act[p]) begin
                        if (rdy) begin
                            chk($sformatf("rand_rdata_p%0d", p), get_rdata(p[0]), model_data(addr[p]));
                            chk($sformatf("rand_error_p%0d", p), 32'(get_error(p[0])), 32'(model_err(addr[p])));
                            chk($sformatf("rand_latency_ok_p%0d", p), 32'((t - start[p]) <= 8), 32'd1);
                            act[p] = 1'b0;
                            gap[p] = int'($urandom_range(0, 3));
                            set_req(p[0], 1'b0, 32'h0);
                        end else if ((t - start[p]) > 8) begin
                            chk($sformatf("rand_no_response_p%0d", p), 32'(rdy), 32'd1);
                            act[p] = 1'b0;
                            gap[p] = 0;
                            set_req(p[0], 1'b0, 32'h0);
                        end
                    end else begin
                        if (rdy) chk($sformatf("rand_spurious_ready_p%0d", p), 32'(rdy), 32'd0);
                        if (gap[p] == 0) begin
                            logic [31:0] w;
                            int unsigned sel;
                            w   = 32'($urandom_range(0, ROM_WORDS - 1));
                            sel = $urandom_range(0, 9);
                            if (sel < 7)       addr[p] = w << 2;
                            else if (sel == 7) addr[p] = 32'h1000 | ($urandom & 32'hFFFF_FFFC);
                            else               addr[p] = (w << 2) | 32'($urandom_range(1, 3));
                            act[p]   = 1'b1;
                            start[p] = t;
                            set_req(p[0], 1'b1, addr[p]);
                        end else begin
                            gap[p]--;
                        end
                    end
                end
            end
            set_req(1'b0, 1'b0, 32'h0);
            set_req(1'b1, 1'b0, 32'h0);
            tick(); tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
